// File: rtl/bus_cycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : bus_cycle_sequencer
// Purpose  : 68000 bus-cycle sequencer. It inserts per-region wait states,
//            waits on the DRAM acknowledge, and times out unanswered cycles
//            into a bus error with the faulting address captured.
// Revision : 1.0
// ============================================================================
module bus_cycle_sequencer #(
   parameter int unsigned ROM_WAIT   = 0,
   parameter int unsigned RAM_WAIT   = 1,
   parameter int unsigned IO_WAIT    = 3,
   parameter int unsigned VGA_WAIT   = 2,
   parameter int unsigned SYNTH_WAIT = 4,
   parameter int unsigned TIMEOUT    = 255
) (
   input  logic        Clock,
   input  logic        Reset_H,
   input  logic        AS_L,
   input  logic        UDS_L,
   input  logic        LDS_L,
   input  logic [31:0] Address,
   input  logic        OnChipRomSelect_H,
   input  logic        OnChipRamSelect_H,
   input  logic        DramSelect_H,
   input  logic        IOSelect_H,
   input  logic        VgaSelect_H,
   input  logic        SynthesizerSelect_H,
   input  logic        DramDtack_L,
   input  logic        ClearFault_H,
   output logic        Dtack_L,
   output logic        Berr_L,
   output logic        Busy_H,
   output logic        FaultFlag_H,
   output logic [31:0] FaultAddress
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_WAIT     = 3'd1,
      S_DRAMWAIT = 3'd2,
      S_UNMAPPED = 3'd3,
      S_ACK      = 3'd4,
      S_BERR     = 3'd5
   } state_t;

   localparam logic [3:0]  c_rom_wait     = 4'(ROM_WAIT);
   localparam logic [3:0]  c_ram_wait     = 4'(RAM_WAIT);
   localparam logic [3:0]  c_io_wait      = 4'(IO_WAIT);
   localparam logic [3:0]  c_vga_wait     = 4'(VGA_WAIT);
   localparam logic [3:0]  c_synth_wait   = 4'(SYNTH_WAIT);
   localparam logic [15:0] c_timeout_last = 16'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [15:0] timer_q, timer_d;
   logic [31:0] cycle_addr_q;
   logic        dram_ack_l_q;
   logic        dtack_l_q, berr_l_q, busy_q, fault_q;
   logic [31:0] fault_addr_q;
   logic        w_request, w_accept, w_enter_berr;

   assign w_request    = ~AS_L & (~UDS_L | ~LDS_L);
   assign w_accept     = (state_q == S_IDLE) & w_request;
   assign w_enter_berr = (state_d == S_BERR) & (state_q != S_BERR);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      timer_d = timer_q;
      case (state_q)
         S_IDLE: begin
            if (w_request) begin
               if (OnChipRomSelect_H) begin
                  state_d = S_WAIT;
                  cnt_d   = c_rom_wait;
               end else if (OnChipRamSelect_H) begin
                  state_d = S_WAIT;
                  cnt_d   = c_ram_wait;
               end else if (IOSelect_H) begin
                  state_d = S_WAIT;
                  cnt_d   = c_io_wait;
               end else if (VgaSelect_H) begin
                  state_d = S_WAIT;
                  cnt_d   = c_vga_wait;
               end else if (SynthesizerSelect_H) begin
                  state_d = S_WAIT;
                  cnt_d   = c_synth_wait;
               end else if (DramSelect_H) begin
                  state_d = S_DRAMWAIT;
                  timer_d = 16'd0;
               end else begin
                  state_d = S_UNMAPPED;
                  timer_d = 16'd0;
               end
            end
         end
         S_WAIT: begin
            if (AS_L)                state_d = S_IDLE;
            else if (cnt_q == 4'd0)  state_d = S_ACK;
            else                     cnt_d   = cnt_q - 4'd1;
         end
         // The registered acknowledge is tested before the timeout so a
         // simultaneous answer still completes the cycle normally.
         S_DRAMWAIT: begin
            if (AS_L)                          state_d = S_IDLE;
            else if (!dram_ack_l_q)            state_d = S_ACK;
            else if (timer_q == c_timeout_last) state_d = S_BERR;
            else                               timer_d = timer_q + 16'd1;
         end
         S_UNMAPPED: begin
            if (AS_L)                          state_d = S_IDLE;
            else if (timer_q == c_timeout_last) state_d = S_BERR;
            else                               timer_d = timer_q + 16'd1;
         end
         S_ACK, S_BERR: begin
            if (AS_L) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset_H) begin
         state_q      <= S_IDLE;
         cnt_q        <= 4'd0;
         timer_q      <= 16'd0;
         cycle_addr_q <= 32'd0;
         dram_ack_l_q <= 1'b1;
         dtack_l_q    <= 1'b1;
         berr_l_q     <= 1'b1;
         busy_q       <= 1'b0;
         fault_q      <= 1'b0;
         fault_addr_q <= 32'd0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         timer_q      <= timer_d;
         // Only acknowledges arriving while already waiting on DRAM count.
         dram_ack_l_q <= (state_q == S_DRAMWAIT) ? DramDtack_L : 1'b1;
         dtack_l_q    <= (state_d != S_ACK);
         berr_l_q     <= (state_d != S_BERR);
         busy_q       <= (state_d != S_IDLE);
         if (w_accept)     cycle_addr_q <= Address;
         if (w_enter_berr) fault_addr_q <= cycle_addr_q;
         if (w_enter_berr)      fault_q <= 1'b1;
         else if (ClearFault_H) fault_q <= 1'b0;
      end
   end

   assign Dtack_L      = dtack_l_q;
   assign Berr_L       = berr_l_q;
   assign Busy_H       = busy_q;
   assign FaultFlag_H  = fault_q;
   assign FaultAddress = fault_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_cycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_cycle_sequencer
// Purpose  : Self-checking bench for bus_cycle_sequencer: directed scenarios
//            plus randomized cycles against an edge-timeline reference model.
// Revision : 1.0
// ============================================================================
module tb_bus_cycle_sequencer;

   localparam int T = 8;
   // Wait states indexed by select bit: ROM, RAM, IO, VGA, SYNTH.
   localparam int W_TAB [5] = '{0, 1, 3, 2, 4};

   logic        Clock = 1'b0;
   logic        Reset_H = 1'b1;
   logic        AS_L = 1'b1, UDS_L = 1'b1, LDS_L = 1'b1;
   logic [31:0] Address = 32'd0;
   logic [5:0]  sel = 6'd0;  // {DRAM, SYNTH, VGA, IO, RAM, ROM}
   logic        DramDtack_L = 1'b1;
   logic        ClearFault_H = 1'b0;
   logic        Dtack_L, Berr_L, Busy_H, FaultFlag_H;
   logic [31:0] FaultAddress;

   int n_checks = 0;
   int n_pass   = 0;

   logic        obs_dtack [0:31];
   logic        obs_berr  [0:31];
   logic        obs_busy  [0:31];
   logic        obs_flag  [0:31];
   logic [31:0] obs_faddr [0:31];

   bus_cycle_sequencer #(
      .ROM_WAIT(0), .RAM_WAIT(1), .IO_WAIT(3), .VGA_WAIT(2), .SYNTH_WAIT(4), .TIMEOUT(T)
   ) dut (
      .Clock(Clock), .Reset_H(Reset_H), .AS_L(AS_L), .UDS_L(UDS_L), .LDS_L(LDS_L),
      .Address(Address),
      .OnChipRomSelect_H(sel[0]), .OnChipRamSelect_H(sel[1]), .IOSelect_H(sel[2]),
      .VgaSelect_H(sel[3]), .SynthesizerSelect_H(sel[4]), .DramSelect_H(sel[5]),
      .DramDtack_L(DramDtack_L), .ClearFault_H(ClearFault_H),
      .Dtack_L(Dtack_L), .Berr_L(Berr_L), .Busy_H(Busy_H),
      .FaultFlag_H(FaultFlag_H), .FaultAddress(FaultAddress)
   );

   always #5 Clock = ~Clock;

   // One bus cycle: edge 0 samples the request; DramDtack_L is sampled low from
   // edge k (k=0: never); AS_L is sampled high from edge r; Reset_H is sampled
   // high only at edge rst_at. Outputs after edge n land in obs_*[n].
   task automatic drive_cycle(input logic [5:0] s, input logic [31:0] a, input int k,
                              input int r, input int rst_at, input logic clr);
      int pick;
      pick = int'($urandom_range(0, 2));
      Address = a; sel = s; AS_L = 1'b0; DramDtack_L = 1'b1; ClearFault_H = clr;
      {UDS_L, LDS_L} = (pick == 0) ? 2'b00 : (pick == 1) ? 2'b01 : 2'b10;
      for (int n = 0; n <= r + 1; n++) begin
         @(posedge Clock); #1;
         obs_dtack[n] = Dtack_L; obs_berr[n] = Berr_L; obs_busy[n] = Busy_H;
         obs_flag[n] = FaultFlag_H; obs_faddr[n] = FaultAddress;
         Reset_H     = (n + 1 == rst_at);
         AS_L        = (n + 1 >= r);
         DramDtack_L = !(k != 0 && n + 1 >= k);
         sel         = 6'($urandom);
         Address     = $urandom;
         if (n + 1 >= r) {UDS_L, LDS_L} = 2'b11;
      end
      sel = 6'd0; DramDtack_L = 1'b1; ClearFault_H = 1'b0; Reset_H = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge Clock);
      #1;
      n_checks++; if (Dtack_L !== 1'b1) $display("FAIL reset_dtack got=%b want=1", Dtack_L); else n_pass++;
      n_checks++; if (Berr_L !== 1'b1) $display("FAIL reset_berr got=%b want=1", Berr_L); else n_pass++;
      n_checks++; if (Busy_H !== 1'b0) $display("FAIL reset_busy got=%b want=0", Busy_H); else n_pass++;
      n_checks++; if (FaultFlag_H !== 1'b0) $display("FAIL reset_flag got=%b want=0", FaultFlag_H); else n_pass++;
      n_checks++; if (FaultAddress !== 32'd0) $display("FAIL reset_faddr got=%h want=0", FaultAddress); else n_pass++;
      Reset_H = 1'b0;
      // Address strobe without any data strobe is not a request.
      AS_L = 1'b0; sel = 6'b000001;
      repeat (2) @(posedge Clock);
      #1;
      n_checks++; if (Busy_H !== 1'b0) $display("FAIL no_data_strobe_busy got=%b want=0", Busy_H); else n_pass++;
      AS_L = 1'b1; sel = 6'd0;
      @(posedge Clock); #1;
   endtask

   task automatic test_rom_basic();
      drive_cycle(6'b000001, 32'h0000_0100, 0, 4, -1, 1'b0);
      n_checks++; if (obs_dtack[0] !== 1'b1 || obs_busy[0] !== 1'b1) $display("FAIL rom_e0 got dtack=%b busy=%b want 1/1", obs_dtack[0], obs_busy[0]); else n_pass++;
      n_checks++; if (obs_dtack[1] !== 1'b0) $display("FAIL rom_dtack_e1 got=%b want=0", obs_dtack[1]); else n_pass++;
      n_checks++; if (obs_dtack[3] !== 1'b0 || obs_berr[3] !== 1'b1) $display("FAIL rom_hold_e3 got dtack=%b berr=%b want 0/1", obs_dtack[3], obs_berr[3]); else n_pass++;
      n_checks++; if (obs_dtack[4] !== 1'b1 || obs_busy[4] !== 1'b0) $display("FAIL rom_release_e4 got dtack=%b busy=%b want 1/0", obs_dtack[4], obs_busy[4]); else n_pass++;
   endtask

   task automatic test_io_wait_abort();
      logic early;
      drive_cycle(6'b000100, 32'h0040_0010, 0, 6, -1, 1'b0);
      early = 1'b0;
      for (int n = 0; n < 4; n++) if (obs_dtack[n] !== 1'b1) early = 1'b1;
      n_checks++; if (early) $display("FAIL io_early_dtack got=low_before_e4 want=high"); else n_pass++;
      n_checks++; if (obs_dtack[4] !== 1'b0) $display("FAIL io_dtack_e4 got=%b want=0", obs_dtack[4]); else n_pass++;
      drive_cycle(6'b000100, 32'h0040_0010, 0, 2, -1, 1'b0);
      early = 1'b0;
      for (int n = 0; n <= 3; n++) if (obs_dtack[n] !== 1'b1 || obs_berr[n] !== 1'b1) early = 1'b1;
      n_checks++; if (early) $display("FAIL io_abort_strobe got=asserted want=none"); else n_pass++;
      n_checks++; if (obs_busy[2] !== 1'b0 || obs_flag[2] !== 1'b0) $display("FAIL io_abort_e2 got busy=%b flag=%b want 0/0", obs_busy[2], obs_flag[2]); else n_pass++;
   endtask

   task automatic test_dram();
      drive_cycle(6'b100000, 32'h0800_0000, 6, 9, -1, 1'b0);
      n_checks++; if (obs_dtack[6] !== 1'b1) $display("FAIL dram_dtack_e6 got=%b want=1", obs_dtack[6]); else n_pass++;
      n_checks++; if (obs_dtack[7] !== 1'b0 || obs_berr[7] !== 1'b1) $display("FAIL dram_dtack_e7 got dtack=%b berr=%b want 0/1", obs_dtack[7], obs_berr[7]); else n_pass++;
      drive_cycle(6'b100000, 32'h0800_0000, 0, 10, -1, 1'b0);
      n_checks++; if (obs_berr[7] !== 1'b1 || obs_flag[7] !== 1'b0) $display("FAIL dram_to_e7 got berr=%b flag=%b want 1/0", obs_berr[7], obs_flag[7]); else n_pass++;
      n_checks++; if (obs_berr[8] !== 1'b0 || obs_dtack[8] !== 1'b1) $display("FAIL dram_berr_e8 got berr=%b dtack=%b want 0/1", obs_berr[8], obs_dtack[8]); else n_pass++;
      n_checks++; if (obs_flag[8] !== 1'b1 || obs_faddr[8] !== 32'h0800_0000) $display("FAIL dram_fault got flag=%b addr=%h want 1/08000000", obs_flag[8], obs_faddr[8]); else n_pass++;
      n_checks++; if (obs_berr[10] !== 1'b1 || obs_busy[10] !== 1'b0) $display("FAIL dram_release got berr=%b busy=%b want 1/0", obs_berr[10], obs_busy[10]); else n_pass++;
   endtask

   task automatic test_unmapped_clear();
      drive_cycle(6'b000000, 32'h2000_0000, 0, 10, -1, 1'b0);
      n_checks++; if (obs_faddr[7] !== 32'h0800_0000) $display("FAIL unm_old_faddr got=%h want=08000000", obs_faddr[7]); else n_pass++;
      n_checks++; if (obs_berr[8] !== 1'b0 || obs_faddr[8] !== 32'h2000_0000) $display("FAIL unm_berr_e8 got berr=%b addr=%h want 0/20000000", obs_berr[8], obs_faddr[8]); else n_pass++;
      ClearFault_H = 1'b1;
      @(posedge Clock); #1;
      ClearFault_H = 1'b0;
      n_checks++; if (FaultFlag_H !== 1'b0 || FaultAddress !== 32'h2000_0000) $display("FAIL clear_fault got flag=%b addr=%h want 0/20000000", FaultFlag_H, FaultAddress); else n_pass++;
      // Clear held across a new fault: the set must win on its edge.
      drive_cycle(6'b000000, 32'h3000_0004, 0, 10, -1, 1'b1);
      n_checks++; if (obs_flag[7] !== 1'b0) $display("FAIL set_wins_e7 got=%b want=0", obs_flag[7]); else n_pass++;
      n_checks++; if (obs_flag[8] !== 1'b1 || obs_faddr[8] !== 32'h3000_0004) $display("FAIL set_wins_e8 got flag=%b addr=%h want 1/30000004", obs_flag[8], obs_faddr[8]); else n_pass++;
      n_checks++; if (obs_flag[9] !== 1'b0) $display("FAIL clear_after_set got=%b want=0", obs_flag[9]); else n_pass++;
   endtask

   task automatic test_priority();
      drive_cycle(6'b000101, 32'h0000_0200, 0, 3, -1, 1'b0);
      n_checks++; if (obs_dtack[1] !== 1'b0) $display("FAIL prio_rom_io got=%b want=0", obs_dtack[1]); else n_pass++;
      drive_cycle(6'b100010, 32'h0010_0000, 0, 4, -1, 1'b0);
      n_checks++; if (obs_dtack[1] !== 1'b1 || obs_dtack[2] !== 1'b0) $display("FAIL prio_ram_dram got e1=%b e2=%b want 1/0", obs_dtack[1], obs_dtack[2]); else n_pass++;
   endtask

   task automatic test_reset_in_ack();
      drive_cycle(6'b000000, 32'h4000_0000, 0, 9, -1, 1'b0);
      n_checks++; if (obs_flag[9] !== 1'b1) $display("FAIL pre_reset_flag got=%b want=1", obs_flag[9]); else n_pass++;
      drive_cycle(6'b000001, 32'h0000_0300, 0, 4, 3, 1'b0);
      n_checks++; if (obs_dtack[2] !== 1'b0) $display("FAIL ack_before_reset got=%b want=0", obs_dtack[2]); else n_pass++;
      n_checks++; if (obs_dtack[3] !== 1'b1 || obs_busy[3] !== 1'b0) $display("FAIL reset_in_ack got dtack=%b busy=%b want 1/0", obs_dtack[3], obs_busy[3]); else n_pass++;
      n_checks++; if (obs_flag[3] !== 1'b0 || obs_faddr[3] !== 32'd0) $display("FAIL reset_in_ack_fault got flag=%b addr=%h want 0/0", obs_flag[3], obs_faddr[3]); else n_pass++;
   endtask

   task automatic test_ack_timeout_tie();
      logic berr_seen;
      drive_cycle(6'b100000, 32'h0800_0040, T - 1, 10, -1, 1'b0);
      berr_seen = 1'b0;
      for (int n = 0; n <= 11; n++) if (obs_berr[n] !== 1'b1) berr_seen = 1'b1;
      n_checks++; if (obs_dtack[T] !== 1'b0) $display("FAIL tie_dtack got=%b want=0", obs_dtack[T]); else n_pass++;
      n_checks++; if (berr_seen || obs_flag[9] !== 1'b0) $display("FAIL tie_berr got berr_seen=%b flag=%b want 0/0", berr_seen, obs_flag[9]); else n_pass++;
   endtask

   // Reference: the response edge follows from the region's rules directly;
   // strobes are low from that edge until the release edge r.
   task automatic test_random();
      logic        m_flag, is_ack, f_ok;
      logic [31:0] m_faddr, a;
      logic [5:0]  s;
      int          idx, k, r, resp;
      m_flag = 1'b0; m_faddr = 32'd0;
      for (int it = 0; it < 60; it++) begin
         s = 6'($urandom);
         if ($urandom_range(0, 3) == 0) s = 6'd0;
         a = $urandom;
         k = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, T + 2)) : 0;
         idx = 6;
         for (int i = 5; i >= 0; i--) if (s[i]) idx = i;
         is_ack = 1'b1;
         if (idx < 5)                           resp = W_TAB[idx] + 1;
         else if (idx == 5 && k != 0 && k + 1 <= T) resp = k + 1;
         else begin resp = T; is_ack = 1'b0; end
         r = int'($urandom_range(1, resp + 3));
         drive_cycle(s, a, k, r, -1, 1'b0);
         for (int n = 0; n <= r; n++) begin
            f_ok = m_flag || (!is_ack && resp < r && n >= resp);
            n_checks++; if (obs_busy[n] !== (n < r)) $display("FAIL rnd_busy it=%0d e%0d got=%b want=%b", it, n, obs_busy[n], n < r); else n_pass++;
            n_checks++; if (obs_dtack[n] !== !(is_ack && n >= resp && n < r)) $display("FAIL rnd_dtack it=%0d sel=%b k=%0d r=%0d e%0d got=%b", it, s, k, r, n, obs_dtack[n]); else n_pass++;
            n_checks++; if (obs_berr[n] !== !(!is_ack && n >= resp && n < r)) $display("FAIL rnd_berr it=%0d sel=%b k=%0d r=%0d e%0d got=%b", it, s, k, r, n, obs_berr[n]); else n_pass++;
            n_checks++; if (obs_flag[n] !== f_ok) $display("FAIL rnd_flag it=%0d e%0d got=%b want=%b", it, n, obs_flag[n], f_ok); else n_pass++;
         end
         if (!is_ack && resp < r) begin m_flag = 1'b1; m_faddr = a; end
         n_checks++; if (obs_faddr[r] !== m_faddr) $display("FAIL rnd_faddr it=%0d got=%h want=%h", it, obs_faddr[r], m_faddr); else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_rom_basic();
      test_io_wait_abort();
      test_dram();
      test_unmapped_clear();
      test_priority();
      test_reset_in_ack();
      test_ack_timeout_tie();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1);
   end

endmodule
`default_nettype wire
